vispart_stream: RTL and testbench

- Transmit end of the interleaved partial-sum stream consumed by the visibility final accumulator.
- Correlator-side logic writes one pass of NSUMS partial sums into a ping-pong buffer, then asserts swap_i.
- The block plays out the completed bank as a contiguous, no-backpressure valid/first/last/data stream.
- It tracks the pass count, so first_o marks every word of pass 0 and last_o marks every word of pass COUNT-1.

---
 rtl/vispart_stream.sv | 144 ++++++++++++++
 tb/tb_vispart_stream.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vispart_stream.sv
// Ping-pong partial-sum buffer that plays out each completed bank as a
// contiguous valid/first/last/data stream tagged with its pass position.
module vispart_stream #(
    parameter int IBITS = 7,
    parameter int NSUMS = 1024,
    parameter int ABITS = $clog2(NSUMS),
    parameter int COUNT = 16,
    parameter int CBITS = $clog2(COUNT + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr_en_i,
    input  logic [ABITS-1:0] wr_addr_i,
    input  logic [IBITS-1:0] wr_data_i,
    input  logic             swap_i,
    output logic             busy_o,
    output logic             overflow_o,
    output logic             valid_o,
    output logic             first_o,
    output logic             last_o,
    output logic [IBITS-1:0] data_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    localparam logic [ABITS-1:0] LP_LAST  = ABITS'(NSUMS - 1);
    localparam logic [ABITS:0]   LP_NSUMS = (ABITS + 1)'(NSUMS);
    localparam logic [CBITS-1:0] LP_CLAST = CBITS'(COUNT - 1);

    logic [IBITS-1:0] r_bank0 [NSUMS];
    logic [IBITS-1:0] r_bank1 [NSUMS];

    logic [0:0]       r_state;
    logic             r_wsel;
    logic [ABITS-1:0] r_raddr;
    logic [CBITS-1:0] r_pass;
    logic             r_pfirst;
    logic             r_plast;
    logic             r_overflow;

    logic             r_rv;
    logic             r_rf;
    logic             r_rl;
    logic [IBITS-1:0] r_rdata;

    logic             r_valid;
    logic             r_first;
    logic             r_last;
    logic [IBITS-1:0] r_data;

    logic             w_emit;
    logic             w_final;
    logic             w_accept;
    logic             w_reject;
    logic             w_wr_ok;
    logic [CBITS-1:0] w_pass_inc;
    logic [CBITS-1:0] w_pass_nx;

    assign w_emit   = (r_state == ST_EMIT);
    assign w_final  = w_emit && (r_raddr == LP_LAST);
    assign w_accept = swap_i && (!w_emit || w_final);
    assign w_reject = swap_i && !w_accept;
    assign w_wr_ok  = ({1'b0, wr_addr_i} < LP_NSUMS);

    assign w_pass_inc = (r_pass == LP_CLAST) ? '0 : r_pass + CBITS'(1);
    // A swap landing on the final read belongs to the pass after this one.
    assign w_pass_nx  = w_final ? w_pass_inc : r_pass;

    always_ff @(posedge clock) begin
        if (wr_en_i && w_wr_ok) begin
            if (r_wsel) begin
                r_bank1[wr_addr_i] <= wr_data_i;
            end else begin
                r_bank0[wr_addr_i] <= wr_data_i;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_emit) begin
            r_rdata <= r_wsel ? r_bank0[r_raddr] : r_bank1[r_raddr];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_wsel     <= 1'b0;
            r_raddr    <= '0;
            r_pass     <= '0;
            r_pfirst   <= 1'b0;
            r_plast    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_reject;
            if (w_final) begin
                r_pass <= w_pass_nx;
            end
            if (w_accept) begin
                r_state  <= ST_EMIT;
                r_wsel   <= ~r_wsel;
                r_raddr  <= '0;
                r_pfirst <= (w_pass_nx == '0);
                r_plast  <= (w_pass_nx == LP_CLAST);
            end else if (w_emit) begin
                if (w_final) begin
                    r_state <= ST_IDLE;
                    r_raddr <= '0;
                end else begin
                    r_raddr <= r_raddr + ABITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rv    <= 1'b0;
            r_rf    <= 1'b0;
            r_rl    <= 1'b0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_rv    <= w_emit;
            r_rf    <= r_pfirst;
            r_rl    <= r_plast;
            r_valid <= r_rv;
            r_first <= r_rv & r_rf;
            r_last  <= r_rv & r_rl;
            r_data  <= r_rv ? r_rdata : '0;
        end
    end

    assign busy_o     = w_emit;
    assign overflow_o = r_overflow;
    assign valid_o    = r_valid;
    assign first_o    = r_first;
    assign last_o     = r_last;
    assign data_o     = r_data;

endmodule

// File: tb/tb_vispart_stream.sv
// Randomised bench for vispart_stream: a bank-level reference model queues
// expected words at swap time and a negedge monitor checks the stream.
module tb_vispart_stream;

    localparam int IBITS = 7;
    localparam int NSUMS = 8;
    localparam int ABITS = 3;
    localparam int COUNT = 3;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             wr_en_i = 1'b0;
    logic [ABITS-1:0] wr_addr_i = '0;
    logic [IBITS-1:0] wr_data_i = '0;
    logic             swap_i = 1'b0;
    logic             busy_o;
    logic             overflow_o;
    logic             valid_o;
    logic             first_o;
    logic             last_o;
    logic [IBITS-1:0] data_o;

    vispart_stream #(
        .IBITS(IBITS),
        .NSUMS(NSUMS),
        .COUNT(COUNT)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .swap_i    (swap_i),
        .busy_o    (busy_o),
        .overflow_o(overflow_o),
        .valid_o   (valid_o),
        .first_o   (first_o),
        .last_o    (last_o),
        .data_o    (data_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        int             cyc;
        logic [IBITS-1:0] d;
        bit             f;
        bit             l;
    } exp_t;

    exp_t q[$];
    bit   busy_at[int];
    bit   ovf_at[int];

    logic [IBITS-1:0] m_bank[2][NSUMS];
    int   m_wsel = 0;
    int   m_pass = 0;
    int   m_busy_until = 0;
    int   edge_cnt = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t mon_e;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0h, expected %0h", nm, edge_cnt, act, exp);
        end
    endtask

    task automatic model_edge(input int e);
        if (wr_en_i && int'(wr_addr_i) < NSUMS)
            m_bank[m_wsel][wr_addr_i] = wr_data_i;
        if (swap_i) begin
            if (e >= m_busy_until) begin
                for (int i = 0; i < NSUMS; i++) begin
                    exp_t x;
                    x.cyc = e + 2 + i;
                    x.d   = m_bank[m_wsel][i];
                    x.f   = (m_pass == 0);
                    x.l   = (m_pass == COUNT - 1);
                    q.push_back(x);
                end
                for (int k = e; k < e + NSUMS; k++) busy_at[k] = 1'b1;
                m_busy_until = e + NSUMS;
                m_wsel = 1 - m_wsel;
                m_pass = (m_pass + 1) % COUNT;
            end else begin
                ovf_at[e] = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        q.delete();
        busy_at.delete();
        ovf_at.delete();
        m_wsel = 0;
        m_pass = 0;
        m_busy_until = 0;
    endtask

    task automatic tick();
        int e;
        e = edge_cnt + 1;
        if (reset_n) model_edge(e);
        @(posedge clock);
        edge_cnt = e;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input int a, input int d);
        wr_en_i = 1'b1;
        wr_addr_i = ABITS'(a);
        wr_data_i = IBITS'(d);
        tick();
        wr_en_i = 1'b0;
    endtask

    task automatic swap_pulse();
        swap_i = 1'b1;
        tick();
        swap_i = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NSUMS; i++) wr(i, $urandom_range(0, 127));
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (valid_o) begin
                if (q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    mon_e = q.pop_front();
                    check("word_cycle", edge_cnt, mon_e.cyc);
                    check("data", data_o, mon_e.d);
                    check("first", first_o, mon_e.f);
                    check("last", last_o, mon_e.l);
                end
            end else begin
                check("idle_outputs", {first_o, last_o, data_o}, 0);
                if (q.size() > 0 && q[0].cyc <= edge_cnt) begin
                    check("missing_word", 0, 1);
                    void'(q.pop_front());
                end
            end
            check("busy", busy_o, busy_at.exists(edge_cnt));
            check("overflow", overflow_o, ovf_at.exists(edge_cnt));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clock);
        #1;
        for (int i = 0; i < 10; i++) begin
            swap_i = 1'($urandom_range(0, 1));
            wr_addr_i = ABITS'($urandom_range(0, NSUMS - 1));
            wr_data_i = IBITS'($urandom_range(0, 127));
            tick();
            check("reset_outputs",
                  {busy_o, overflow_o, valid_o, first_o, last_o, data_o}, 0);
        end
        swap_i = 1'b0;
        model_reset();
        reset_n = 1'b1;
        idle(100);

        for (int i = 0; i < NSUMS; i++) wr(i, 10 + i);
        swap_pulse();
        idle(12);

        fill_random();
        swap_pulse();
        idle(12);
        fill_random();
        swap_pulse();
        idle(12);
        fill_random();
        swap_pulse();
        idle(12);

        swap_pulse();
        idle(3);
        swap_pulse();
        idle(12);

        swap_pulse();
        for (int i = 0; i < NSUMS - 1; i++) wr(i, $urandom_range(0, 127));
        wr_en_i = 1'b1;
        wr_addr_i = ABITS'(NSUMS - 1);
        wr_data_i = IBITS'($urandom_range(0, 127));
        swap_i = 1'b1;
        tick();
        wr_en_i = 1'b0;
        swap_i = 1'b0;
        idle(12);

        for (int i = 0; i < NSUMS; i++) wr(i, i);
        swap_pulse();
        for (int i = 0; i < NSUMS; i++) wr(i, 'h55);
        idle(12);

        for (int i = 0; i < 400; i++) begin
            wr_en_i = 1'($urandom_range(0, 1));
            wr_addr_i = ABITS'($urandom_range(0, NSUMS - 1));
            wr_data_i = IBITS'($urandom_range(0, 127));
            swap_i = ($urandom_range(0, 9) == 0);
            tick();
        end
        wr_en_i = 1'b0;
        swap_i = 1'b0;
        idle(14);

        swap_pulse();
        idle(6);
        reset_n = 1'b0;
        #1;
        check("reset_mid_outputs",
              {busy_o, overflow_o, valid_o, first_o, last_o, data_o}, 0);
        model_reset();
        idle(3);
        reset_n = 1'b1;
        idle(5);
        swap_pulse();
        idle(12);

        check("drain_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
